regfile_port_sequencer: RTL and testbench
=========================================

Name: regfile_port_sequencer

Overview:
- Control stage directly upstream of the register-file latch array built from dual-read-port D-latch bit cells. One array row is one register.
- Each request is decoded into complementary per-row read enables for ports 1 and 2, and into complementary per-row latch clocks. The write data bus is driven to the array.
- Both tristate read buses are sampled into operand registers. An optional writeback is then sequenced with setup/pulse/hold phases. Requests and responses use valid/ready handshakes.

Parameters:
NREGS, 32, number of register rows; row 0 is hardwired zero
AW, 5, register address width, equal to clog2(NREGS)
XLEN, 32, data width

Ports:
CLK  in  1  system clock, rising edge
nRST  in  1  asynchronous active-low reset
REQ_VALID  in  1  request valid
REQ_READY  out  1  sequencer idle, request accepted when REQ_VALID is also high
RS1  in  AW  read port 1 row address
RS2  in  AW  read port 2 row address
RD  in  AW  write row address
WR_EN  in  1  request includes a write
WR_DATA  in  XLEN  write value
EN1  out  NREGS  one-hot read enable, port 1
nEN1  out  NREGS  complement of EN1
EN2  out  NREGS  one-hot read enable, port 2
nEN2  out  NREGS  complement of EN2
WCLK  out  NREGS  one-hot row latch clock, latch transparent while high
nWCLK  out  NREGS  complement of WCLK
WDATA  out  XLEN  D bus to the array
Q1_BUS  in  XLEN  shared read bus, port 1
Q2_BUS  in  XLEN  shared read bus, port 2
RSP_VALID  out  1  OP1/OP2 valid
RSP_READY  in  1  response accepted
OP1  out  XLEN  captured port-1 value
OP2  out  XLEN  captured port-2 value

Behaviour:
- One clock domain. nRST is asynchronous assert, synchronous deassert (deassertion synchronised externally).
- All outputs are registered except REQ_READY. REQ_READY = (state == IDLE).
- Each n-output equals the bitwise inverse of its partner in every cycle, including during reset.
- States, with transitions taken at the rising edge of CLK:
  - IDLE: on REQ_VALID, latch RS1, RS2, RD, WR_EN and WR_DATA. Go to RD.
  - RD: EN1[rs1] and EN2[rs2] are high; buses settle. Go to CAP.
  - CAP: enables stay high. At the end of the cycle, OP1 ← Q1_BUS and OP2 ← Q2_BUS. Go to WSETUP if WR_EN and rd≠0, otherwise go to RESP. Enables drop on the same edge.
  - WSETUP: WDATA = wr_data, all WCLK low. Go to WPULSE.
  - WPULSE: WCLK[rd] high, WDATA held. Go to WHOLD.
  - WHOLD: WCLK low, WDATA held. Go to RESP.
  - RESP: RSP_VALID high. OP1 and OP2 are stable until RSP_READY is seen; then go to IDLE.
- Latency from the accept edge to RSP_VALID: 3 cycles for a read-only request, 6 cycles with a write. Back-to-back throughput: one request per 4 or 7 cycles, because REQ_READY is low outside IDLE.
- Row 0:
  - EN1[0], EN2[0] and WCLK[0] are never asserted.
  - RS1 = 0 forces OP1 = 0 and RS2 = 0 forces OP2 = 0, regardless of bus contents.
  - A write to RD = 0 skips WSETUP, WPULSE and WHOLD.
- Ordering and overlap:
  - Read enables and WCLK are never high in the same cycle.
  - At most one WCLK bit is high at any time, and it is high for exactly one cycle.
  - WDATA is stable from WSETUP through WHOLD inclusive.
- Hazards:
  - RS1 = RS2 enables the same row on both ports; this is legal.
  - RD = RS1 or RD = RS2 returns the old value, because the read precedes the write.
  - Inputs are ignored outside IDLE.
- Reset value of every output: EN1, EN2 and WCLK all 0; nEN1, nEN2 and nWCLK all 1s; WDATA 0; OP1 and OP2 0; RSP_VALID 0; REQ_READY 1.
- Reset asserted mid-operation forces IDLE and the reset values immediately and asynchronously. The WCLK pulse is truncated: the row keeps whatever it latched, and no response is issued.

Test Plan:
- Read-only, RS1=3, RS2=7: bench drives Q1_BUS/Q2_BUS only while the matching enable is high. EN1=0x8 and EN2=0x80 in cycles 1-2; OP1/OP2 carry the bus values with RSP_VALID at cycle 3; nEN1=~0x8.
- Write RD=5, WR_DATA=0xDEADBEEF: WDATA is valid in cycles 3-5; WCLK=0x20 only in cycle 4; RSP_VALID at cycle 6. A following read of RS1=5 via a latch model returns 0xDEADBEEF.
- RS1=0, RS2=0, RD=0 with WR_EN: no enable or WCLK bit is ever high; OP1=OP2=0; RSP_VALID at cycle 3.
- RD=RS1=9, array holds 0x11, WR_DATA=0x22: OP1=0x11; a later read returns 0x22.
- RSP_READY held low 4 cycles: RSP_VALID, OP1 and OP2 stay stable and REQ_READY stays 0; on RSP_READY the FSM returns to IDLE and the next request is accepted.
- nRST pulsed during WPULSE: WCLK drops without waiting for a clock edge, all outputs take their reset values, REQ_READY=1, and no response follows.

Source files
------------

// File: rtl/regfile_port_sequencer_if.sv
// Bundle of request, array-side and response signals between the
// regfile sequencer and its surroundings (requester plus latch array).
interface regfile_port_sequencer_if #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int XLEN  = 32
);
    // Request channel
    logic             REQ_VALID;
    logic             REQ_READY;
    logic [AW-1:0]    RS1;
    logic [AW-1:0]    RS2;
    logic [AW-1:0]    RD;
    logic             WR_EN;
    logic [XLEN-1:0]  WR_DATA;

    // Latch array control and data
    logic [NREGS-1:0] EN1;
    logic [NREGS-1:0] nEN1;
    logic [NREGS-1:0] EN2;
    logic [NREGS-1:0] nEN2;
    logic [NREGS-1:0] WCLK;
    logic [NREGS-1:0] nWCLK;
    logic [XLEN-1:0]  WDATA;
    logic [XLEN-1:0]  Q1_BUS;
    logic [XLEN-1:0]  Q2_BUS;

    // Response channel
    logic             RSP_VALID;
    logic             RSP_READY;
    logic [XLEN-1:0]  OP1;
    logic [XLEN-1:0]  OP2;

    // Requester/array side: issues requests, drives the read buses
    modport master (
        output REQ_VALID, RS1, RS2, RD, WR_EN, WR_DATA,
        output Q1_BUS, Q2_BUS, RSP_READY,
        input  REQ_READY, EN1, nEN1, EN2, nEN2, WCLK, nWCLK, WDATA,
        input  RSP_VALID, OP1, OP2
    );

    // Sequencer side
    modport slave (
        input  REQ_VALID, RS1, RS2, RD, WR_EN, WR_DATA,
        input  Q1_BUS, Q2_BUS, RSP_READY,
        output REQ_READY, EN1, nEN1, EN2, nEN2, WCLK, nWCLK, WDATA,
        output RSP_VALID, OP1, OP2
    );
endinterface

// File: rtl/regfile_port_sequencer.sv
// Control stage in front of a dual-read-port latch register file.
// Each accepted request reads two rows onto the shared tristate buses,
// captures them into operand registers, optionally sequences a single
// row write with setup/pulse/hold phases, then presents the operands.
// Row 0 is hardwired zero: it is never enabled, never written, and
// reading it returns 0 regardless of what is on the bus.
module regfile_port_sequencer #(
    parameter int NREGS = 32,
    parameter int AW    = 5,
    parameter int XLEN  = 32
) (
    input logic                   CLK,
    input logic                   nRST,
    regfile_port_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_CAP,
        S_WSETUP,
        S_WPULSE,
        S_WHOLD,
        S_RESP
    } state_t;

    state_t           state;

    // Request fields held for the whole transaction
    logic [AW-1:0]    rs1_q;
    logic [AW-1:0]    rs2_q;
    logic [AW-1:0]    rd_q;
    logic             wr_en_q;
    logic [XLEN-1:0]  wr_data_q;

    // Registered outputs
    logic [NREGS-1:0] en1_q;
    logic [NREGS-1:0] en2_q;
    logic [NREGS-1:0] wclk_q;
    logic [XLEN-1:0]  wdata_q;
    logic [XLEN-1:0]  op1_q;
    logic [XLEN-1:0]  op2_q;
    logic             rsp_valid_q;

    // One-hot row decode; row 0 never gets a bit so it can never be
    // driven onto a bus or opened for writing.
    function automatic logic [NREGS-1:0] row_select(input logic [AW-1:0] addr);
        logic [NREGS-1:0] sel;
        sel = '0;
        if (addr != '0 && int'(addr) < NREGS) begin
            sel[addr] = 1'b1;
        end
        return sel;
    endfunction

    // Whole transaction sequence: request latch, read, capture, optional
    // write phases, response hold. Enables are dropped on the same edge
    // that captures the buses, so enables and WCLK never overlap.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= S_IDLE;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            en1_q       <= '0;
            en2_q       <= '0;
            wclk_q      <= '0;
            wdata_q     <= '0;
            op1_q       <= '0;
            op2_q       <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.REQ_VALID) begin
                        rs1_q     <= bus.RS1;
                        rs2_q     <= bus.RS2;
                        rd_q      <= bus.RD;
                        wr_en_q   <= bus.WR_EN;
                        wr_data_q <= bus.WR_DATA;
                        en1_q     <= row_select(bus.RS1);
                        en2_q     <= row_select(bus.RS2);
                        state     <= S_RD;
                    end
                end

                S_RD: begin
                    state <= S_CAP;
                end

                S_CAP: begin
                    op1_q <= (rs1_q == '0) ? '0 : bus.Q1_BUS;
                    op2_q <= (rs2_q == '0) ? '0 : bus.Q2_BUS;
                    en1_q <= '0;
                    en2_q <= '0;
                    if (wr_en_q && rd_q != '0) begin
                        wdata_q <= wr_data_q;
                        state   <= S_WSETUP;
                    end else begin
                        rsp_valid_q <= 1'b1;
                        state       <= S_RESP;
                    end
                end

                S_WSETUP: begin
                    wclk_q <= row_select(rd_q);
                    state  <= S_WPULSE;
                end

                S_WPULSE: begin
                    wclk_q <= '0;
                    state  <= S_WHOLD;
                end

                S_WHOLD: begin
                    rsp_valid_q <= 1'b1;
                    state       <= S_RESP;
                end

                S_RESP: begin
                    if (bus.RSP_READY) begin
                        rsp_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Complements are plain inversions of the registers, so they track
    // their partners in every cycle, reset included.
    assign bus.EN1       = en1_q;
    assign bus.nEN1      = ~en1_q;
    assign bus.EN2       = en2_q;
    assign bus.nEN2      = ~en2_q;
    assign bus.WCLK      = wclk_q;
    assign bus.nWCLK     = ~wclk_q;
    assign bus.WDATA     = wdata_q;
    assign bus.OP1       = op1_q;
    assign bus.OP2       = op2_q;
    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.REQ_READY = (state == S_IDLE);

endmodule

// File: tb/tb_regfile_port_sequencer.sv
// Bench for regfile_port_sequencer: models the latch array that sits
// behind the sequencer, and predicts every transaction from the
// register-file rules with a plain array of register contents.
module tb_regfile_port_sequencer;

    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int XLEN  = 32;

    logic clk = 1'b0;
    logic resetN;

    always #5 clk = ~clk;

    regfile_port_sequencer_if #(.NREGS(NREGS), .AW(AW), .XLEN(XLEN)) bus();

    regfile_port_sequencer #(.NREGS(NREGS), .AW(AW), .XLEN(XLEN)) dut (
        .CLK  (clk),
        .nRST (resetN),
        .bus  (bus)
    );

    logic [XLEN-1:0] latchArray [NREGS];
    logic [XLEN-1:0] refRegs    [NREGS];
    logic [XLEN-1:0] noise1;
    logic [XLEN-1:0] noise2;
    bit              arrayLoaded = 1'b0;

    int compareCount  = 0;
    int mismatchCount = 0;

    // Latch array: rows take WDATA while their WCLK is high; the bus
    // noise changes every cycle so a mistimed capture is visible.
    always @(negedge clk) begin
        if (!arrayLoaded) begin
            for (int i = 0; i < NREGS; i++) latchArray[i] = refRegs[i];
            arrayLoaded = 1'b1;
        end
        noise1 = $urandom;
        noise2 = $urandom;
        for (int i = 0; i < NREGS; i++) begin
            if (bus.WCLK[i]) latchArray[i] = bus.WDATA;
        end
    end

    // Read buses carry a row only while that row's enable is high.
    always_comb begin
        bus.Q1_BUS = noise1;
        bus.Q2_BUS = noise2;
        for (int i = 0; i < NREGS; i++) begin
            if (bus.EN1[i]) bus.Q1_BUS = latchArray[i];
            if (bus.EN2[i]) bus.Q2_BUS = latchArray[i];
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compareCount++;
        if (observed !== expected) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [NREGS-1:0] rowBit(input int idx);
        return (idx == 0) ? '0 : (NREGS'(1) << idx);
    endfunction

    task automatic checkResetValues(input string where);
        logic [NREGS-1:0] allOnes;
        allOnes = '1;
        checkOutput({where, " EN1"},       bus.EN1, '0);
        checkOutput({where, " nEN1"},      bus.nEN1, allOnes);
        checkOutput({where, " EN2"},       bus.EN2, '0);
        checkOutput({where, " nEN2"},      bus.nEN2, allOnes);
        checkOutput({where, " WCLK"},      bus.WCLK, '0);
        checkOutput({where, " nWCLK"},     bus.nWCLK, allOnes);
        checkOutput({where, " WDATA"},     bus.WDATA, '0);
        checkOutput({where, " OP1"},       bus.OP1, '0);
        checkOutput({where, " OP2"},       bus.OP2, '0);
        checkOutput({where, " RSP_VALID"}, bus.RSP_VALID, 0);
        checkOutput({where, " REQ_READY"}, bus.REQ_READY, 1);
    endtask

    task automatic presentRequest(input int rs1, input int rs2, input int rd,
                                  input bit wrEn, input logic [XLEN-1:0] wrData);
        @(negedge clk);
        checkOutput("idle REQ_READY", bus.REQ_READY, 1);
        checkOutput("idle RSP_VALID", bus.RSP_VALID, 0);
        bus.REQ_VALID = 1'b1;
        bus.RS1       = AW'(rs1);
        bus.RS2       = AW'(rs2);
        bus.RD        = AW'(rd);
        bus.WR_EN     = wrEn;
        bus.WR_DATA   = wrData;
        @(posedge clk);
        #1;
        // Fields are scrambled after the accept edge; the sequencer must ignore them.
        bus.REQ_VALID = 1'b0;
        bus.RS1       = AW'($urandom);
        bus.RS2       = AW'($urandom);
        bus.RD        = AW'($urandom);
        bus.WR_EN     = 1'($urandom);
        bus.WR_DATA   = $urandom;
    endtask

    task automatic checkCycle(input int cyc, input int rs1, input int rs2, input int rd,
                              input bit doesWrite, input int latency,
                              input logic [XLEN-1:0] wrData);
        logic [NREGS-1:0] expEn1, expEn2, expWclk, nExpEn1, nExpEn2, nExpWclk;
        expEn1   = (cyc <= 2) ? rowBit(rs1) : '0;
        expEn2   = (cyc <= 2) ? rowBit(rs2) : '0;
        expWclk  = (doesWrite && cyc == 4) ? rowBit(rd) : '0;
        nExpEn1  = ~expEn1;
        nExpEn2  = ~expEn2;
        nExpWclk = ~expWclk;
        checkOutput($sformatf("EN1 c%0d", cyc),       bus.EN1, expEn1);
        checkOutput($sformatf("nEN1 c%0d", cyc),      bus.nEN1, nExpEn1);
        checkOutput($sformatf("EN2 c%0d", cyc),       bus.EN2, expEn2);
        checkOutput($sformatf("nEN2 c%0d", cyc),      bus.nEN2, nExpEn2);
        checkOutput($sformatf("WCLK c%0d", cyc),      bus.WCLK, expWclk);
        checkOutput($sformatf("nWCLK c%0d", cyc),     bus.nWCLK, nExpWclk);
        checkOutput($sformatf("RSP_VALID c%0d", cyc), bus.RSP_VALID, (cyc == latency) ? 1 : 0);
        checkOutput($sformatf("REQ_READY c%0d", cyc), bus.REQ_READY, 0);
        if (doesWrite && cyc >= 3 && cyc <= 5) begin
            checkOutput($sformatf("WDATA c%0d", cyc), bus.WDATA, wrData);
        end
    endtask

    // One full transaction: request, per-cycle sequencing, response hold, release.
    task automatic applyStimulus(input int rs1, input int rs2, input int rd, input bit wrEn,
                                 input logic [XLEN-1:0] wrData, input int holdCycles);
        bit              doesWrite;
        int              latency;
        logic [XLEN-1:0] exp1, exp2;
        doesWrite = wrEn && (rd != 0);
        latency   = doesWrite ? 6 : 3;
        exp1      = (rs1 == 0) ? '0 : refRegs[rs1];
        exp2      = (rs2 == 0) ? '0 : refRegs[rs2];

        presentRequest(rs1, rs2, rd, wrEn, wrData);
        for (int cyc = 1; cyc <= latency; cyc++) begin
            @(negedge clk);
            checkCycle(cyc, rs1, rs2, rd, doesWrite, latency, wrData);
        end
        checkOutput($sformatf("OP1 rs1=%0d", rs1), bus.OP1, exp1);
        checkOutput($sformatf("OP2 rs2=%0d", rs2), bus.OP2, exp2);

        for (int k = 0; k < holdCycles; k++) begin
            @(negedge clk);
            checkOutput("hold RSP_VALID", bus.RSP_VALID, 1);
            checkOutput("hold OP1",       bus.OP1, exp1);
            checkOutput("hold OP2",       bus.OP2, exp2);
            checkOutput("hold REQ_READY", bus.REQ_READY, 0);
        end

        bus.RSP_READY = 1'b1;
        @(posedge clk);
        #1;
        bus.RSP_READY = 1'b0;

        if (doesWrite) refRegs[rd] = wrData;
    endtask

    // Write cut short by reset while its WCLK pulse is high.
    task automatic resetDuringWrite(input int rd, input logic [XLEN-1:0] wrData);
        presentRequest(1, 2, rd, 1'b1, wrData);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            checkCycle(cyc, 1, 2, rd, 1'b1, 6, wrData);
        end
        #1;
        resetN = 1'b0;
        #1;
        checkResetValues("mid-reset");
        @(posedge clk);
        #1;
        resetN = 1'b1;
        // The row was transparent for half the pulse and keeps that value.
        refRegs[rd] = wrData;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checkOutput("post-reset RSP_VALID", bus.RSP_VALID, 0);
            checkOutput("post-reset REQ_READY", bus.REQ_READY, 1);
            checkOutput("post-reset WCLK",      bus.WCLK, '0);
        end
    endtask

    initial begin
        int r1, r2, rdv, hold;
        bit we;
        logic [XLEN-1:0] data;

        resetN        = 1'b0;
        bus.REQ_VALID = 1'b0;
        bus.RS1       = '0;
        bus.RS2       = '0;
        bus.RD        = '0;
        bus.WR_EN     = 1'b0;
        bus.WR_DATA   = '0;
        bus.RSP_READY = 1'b0;
        for (int i = 0; i < NREGS; i++) refRegs[i] = $urandom;

        @(posedge clk);
        #1;
        checkResetValues("reset");
        @(posedge clk);
        #1;
        resetN = 1'b1;

        $display("[TB] directed transactions");
        applyStimulus(3, 7, 0, 1'b0, 32'h0, 0);
        applyStimulus(1, 2, 5, 1'b1, 32'hDEADBEEF, 0);
        applyStimulus(5, 4, 0, 1'b0, 32'h0, 0);
        applyStimulus(0, 0, 0, 1'b1, 32'hCAFEF00D, 0);
        applyStimulus(9, 9, 9, 1'b1, 32'h11, 0);
        applyStimulus(9, 3, 9, 1'b1, 32'h22, 0);
        applyStimulus(9, 9, 0, 1'b0, 32'h0, 0);
        applyStimulus(6, 8, 0, 1'b0, 32'h0, 4);
        applyStimulus(8, 6, 12, 1'b1, 32'h12345678, 4);

        $display("[TB] reset during write pulse");
        resetDuringWrite(17, 32'hA5A5A5A5);
        applyStimulus(17, 0, 0, 1'b0, 32'h0, 0);

        $display("[TB] random transactions");
        for (int n = 0; n < 60; n++) begin
            r1   = $urandom_range(0, NREGS - 1);
            r2   = $urandom_range(0, NREGS - 1);
            if ($urandom_range(0, 7) == 0) r1 = 0;
            if ($urandom_range(0, 7) == 0) r2 = r1;
            rdv  = ($urandom_range(0, 3) == 0) ? r1 : $urandom_range(0, NREGS - 1);
            we   = 1'($urandom_range(0, 1));
            data = $urandom;
            hold = $urandom_range(0, 3);
            applyStimulus(r1, r2, rdv, we, data, hold);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
